// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator for one synchronous single-port SRAM bank.
// Define SRAM_BIST_ERRCNT_EN to run to completion and count every mismatch on err_count.
module sram_bist_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
`ifdef SRAM_BIST_ERRCNT_EN
  output logic [15:0]       err_count,
`endif
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] wd,
  output logic              banksel,
  output logic              read,
  output logic              write,
  input  logic [DATA_W-1:0] dataout
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] D1        = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]   pend_exp_q, pend_exp_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0]   fail_got_q, fail_got_d;
`ifdef SRAM_BIST_ERRCNT_EN
  logic [15:0]         err_count_q, err_count_d;
`endif

  logic                access, el_desc, el_has_rd, el_has_wr, el_rd_one, el_wr_one;
  logic                two_op, is_rd_cycle, is_wr_cycle, last_addr, mismatch;
  logic [DATA_W-1:0]   rd_word, wr_word;
  state_t              next_el;
  logic [ADDR_W-1:0]   next_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      phase_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_exp_q   <= '0;
      pend_addr_q  <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_exp_q   <= '0;
      fail_got_q   <= '0;
`ifdef SRAM_BIST_ERRCNT_EN
      err_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      pend_valid_q <= pend_valid_d;
      pend_exp_q   <= pend_exp_d;
      pend_addr_q  <= pend_addr_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_exp_q   <= fail_exp_d;
      fail_got_q   <= fail_got_d;
`ifdef SRAM_BIST_ERRCNT_EN
      err_count_q  <= err_count_d;
`endif
    end
  end

  // March element decode: direction, which ops are present, and their background words.
  always_comb begin
    access    = 1'b1;
    el_desc   = 1'b0;
    el_has_rd = 1'b0;
    el_has_wr = 1'b0;
    el_rd_one = 1'b0;
    el_wr_one = 1'b0;
    case (state_q)
      S_M0: el_has_wr = 1'b1;
      S_M1: begin el_has_rd = 1'b1; el_has_wr = 1'b1; el_wr_one = 1'b1; end
      S_M2: begin el_has_rd = 1'b1; el_has_wr = 1'b1; el_rd_one = 1'b1; end
      S_M3: begin el_desc = 1'b1; el_has_rd = 1'b1; el_has_wr = 1'b1; el_wr_one = 1'b1; end
      S_M4: begin el_desc = 1'b1; el_has_rd = 1'b1; el_has_wr = 1'b1; el_rd_one = 1'b1; end
      S_M5: el_has_rd = 1'b1;
      default: access = 1'b0;
    endcase
  end

  // Each element hands over to the next one at that element's own start address.
  always_comb begin
    next_el    = S_DRAIN;
    next_start = '0;
    case (state_q)
      S_M0: next_el = S_M1;
      S_M1: next_el = S_M2;
      S_M2: begin next_el = S_M3; next_start = ADDR_LAST; end
      S_M3: begin next_el = S_M4; next_start = ADDR_LAST; end
      S_M4: next_el = S_M5;
      default: next_el = S_DRAIN;
    endcase
  end

  assign two_op      = el_has_rd & el_has_wr;
  assign is_rd_cycle = access & el_has_rd & (~two_op | ~phase_q);
  assign is_wr_cycle = access & el_has_wr & (~two_op | phase_q);
  assign last_addr   = el_desc ? (addr_q == '0) : (addr_q == ADDR_LAST);
  assign rd_word     = el_rd_one ? D1 : '0;
  assign wr_word     = el_wr_one ? D1 : '0;
  assign mismatch    = pend_valid_q & (dataout != pend_exp_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    pend_valid_d = is_rd_cycle;
    pend_exp_d   = pend_exp_q;
    pend_addr_d  = pend_addr_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_exp_d   = fail_exp_q;
    fail_got_d   = fail_got_q;
`ifdef SRAM_BIST_ERRCNT_EN
    err_count_d  = err_count_q;
`endif

    if (is_rd_cycle) begin
      pend_exp_d  = rd_word;
      pend_addr_d = addr_q;
    end

    if (access) begin
      if (two_op && !phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (last_addr) begin
          state_d = next_el;
          addr_d  = next_start;
        end else begin
          addr_d = el_desc ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
      end
    end else if (state_q == S_DRAIN) begin
      state_d = S_DONE;
    end

    // Only the first mismatch is captured; the fail flag is sticky for the run.
    if (mismatch) begin
      if (!fail_q) begin
        fail_addr_d = pend_addr_q;
        fail_exp_d  = pend_exp_q;
        fail_got_d  = dataout;
      end
      fail_d = 1'b1;
`ifdef SRAM_BIST_ERRCNT_EN
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
`else
      state_d      = S_DONE;
      addr_d       = '0;
      phase_d      = 1'b0;
      pend_valid_d = 1'b0;
`endif
    end

    if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d      = S_M0;
      addr_d       = '0;
      phase_d      = 1'b0;
      pend_valid_d = 1'b0;
      fail_d       = 1'b0;
      fail_addr_d  = '0;
      fail_exp_d   = '0;
      fail_got_d   = '0;
`ifdef SRAM_BIST_ERRCNT_EN
      err_count_d  = '0;
`endif
    end
  end

  assign busy      = access | (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;
`ifdef SRAM_BIST_ERRCNT_EN
  assign err_count = err_count_q;
`endif
  assign ADDRESS   = addr_q;
  assign wd        = is_wr_cycle ? wr_word : '0;
  assign banksel   = access;
  assign read      = is_rd_cycle;
  assign write     = is_wr_cycle;

endmodule
